// File: rtl/fft_ofdm_pkg.sv
// ============================================================================
// Module   : fft_ofdm_pkg
// Purpose  : Shared sizes, complex-bin type and index helpers for the FFT/OFDM path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fft_ofdm_pkg;

  localparam int N     = 16;
  localparam int BINS  = 16;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic signed [N-1:0] re;
    logic signed [N-1:0] im;
  } cplx_t;

  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    for (int b = 0; b < IDX_W; b++) begin
      r[b] = idx[IDX_W-1-b];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_bank.sv
// ============================================================================
// Module   : fft_frame_bank
// Purpose  : One frame of BINS complex bins, parallel load, combinational indexed read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_frame_bank
  import fft_ofdm_pkg::*;
(
  input  logic                clk_i,
  input  logic                load_i,
  input  logic [BINS*N-1:0]   bins_re_i,
  input  logic [BINS*N-1:0]   bins_im_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [2*N-1:0]      rd_data_o
);

  cplx_t mem_q [BINS];

  // Payload registers need no reset: the owner's full flag decides whether they are visible.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      for (int k = 0; k < BINS; k++) begin
        mem_q[k].re <= bins_re_i[k*N +: N];
        mem_q[k].im <= bins_im_i[k*N +: N];
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/fft_bin_serializer.sv
// ============================================================================
// Module   : fft_bin_serializer
// Purpose  : Captures a 16-bin FFT frame into ping-pong banks and streams it out beat by beat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_bin_serializer
  import fft_ofdm_pkg::*;
#(
  parameter int BITREV = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BINS*N-1:0]   i_bins_re,
  input  logic [BINS*N-1:0]   i_bins_im,
  input  logic                i_frame_done,
  output logic [2*N-1:0]      o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [IDX_W-1:0]    o_index,
  output logic                o_last,
  output logic                o_overflow,
  output logic [7:0]          o_drop_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       load;
  logic [2*N-1:0]   bank_data [2];
  logic             xfer, rel, free, capture;

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_frame_bank u_bank (
        .clk_i     (i_clk),
        .load_i    (load[b]),
        .bins_re_i (i_bins_re),
        .bins_im_i (i_bins_im),
        .rd_idx_i  (rd_idx),
        .rd_data_o (bank_data[b])
      );
    end
  endgenerate

  assign rd_idx     = (BITREV != 0) ? bitrev(idx_q) : idx_q;
  assign o_valid    = full_q[rd_bank_q];
  assign o_data     = o_valid ? bank_data[rd_bank_q] : '0;
  assign o_index    = rd_idx;
  assign o_last     = o_valid && (idx_q == LAST_IDX);
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_cnt_q;

  always_comb begin
    xfer       = o_valid && i_ready;
    rel        = xfer && (idx_q == LAST_IDX);
    // A bank being released this cycle may be refilled in the same cycle.
    free       = !full_q[wr_bank_q] || (rel && (rd_bank_q == wr_bank_q));
    capture    = i_frame_done && free && !i_rst;
    load       = 2'b00;
    load[wr_bank_q] = capture;

    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    idx_d      = idx_q;
    ovf_d      = i_frame_done && !free;
    drop_cnt_d = drop_cnt_q;

    if (ovf_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    if (xfer) begin
      idx_d = rel ? '0 : idx_q + IDX_W'(1);
    end
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    if (capture) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_bin_serializer.sv
// ============================================================================
// Module   : tb_fft_bin_serializer
// Purpose  : Randomized and directed bench for fft_bin_serializer (natural and bit-reversed order).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fft_bin_serializer;

  localparam int N     = 16;
  localparam int BINS  = 16;
  localparam int IDX_W = 4;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_frame_done;
  logic                i_ready;
  logic [BINS*N-1:0]   i_bins_re;
  logic [BINS*N-1:0]   i_bins_im;

  logic [2*N-1:0]      data0, data1;
  logic                valid0, valid1, last0, last1, ovf0, ovf1;
  logic [IDX_W-1:0]    idx0, idx1;
  logic [7:0]          cnt0, cnt1;

  always #5 i_clk = ~i_clk;

  fft_bin_serializer #(.BITREV(0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_bins_re(i_bins_re), .i_bins_im(i_bins_im),
    .i_frame_done(i_frame_done), .o_data(data0), .o_valid(valid0), .i_ready(i_ready),
    .o_index(idx0), .o_last(last0), .o_overflow(ovf0), .o_drop_cnt(cnt0)
  );

  fft_bin_serializer #(.BITREV(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_bins_re(i_bins_re), .i_bins_im(i_bins_im),
    .i_frame_done(i_frame_done), .o_data(data1), .o_valid(valid1), .i_ready(i_ready),
    .o_index(idx1), .o_last(last1), .o_overflow(ovf1), .o_drop_cnt(cnt1)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: an ordered queue of stored frames, the beat position in the head frame,
  // the pending overflow pulse and the saturating drop count.
  typedef struct {
    logic [BINS*N-1:0] re;
    logic [BINS*N-1:0] im;
  } frame_t;

  frame_t m_q[$];
  int     m_beat  = 0;
  logic   m_ovf   = 1'b0;
  int     m_drops = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rev_idx(input int k);
    int r = 0;
    for (int b = 0; b < IDX_W; b++) begin
      if (k[b]) r = r | (1 << (IDX_W - 1 - b));
    end
    return r;
  endfunction

  task automatic check_dut(input string s, input bit rev, input logic v, input logic [2*N-1:0] d,
                           input logic [IDX_W-1:0] ix, input logic l, input logic o,
                           input logic [7:0] c);
    logic          ev;
    int            m;
    logic [2*N-1:0] ed;
    ev = (m_q.size() > 0);
    m  = rev ? rev_idx(m_beat) : m_beat;
    ed = '0;
    if (ev) ed = {m_q[0].re[m*N +: N], m_q[0].im[m*N +: N]};
    chk({"valid", s}, 64'(v), 64'(ev));
    chk({"data", s}, 64'(d), 64'(ed));
    chk({"index", s}, 64'(ix), 64'(m));
    chk({"last", s}, 64'(l), 64'(ev && (m_beat == BINS - 1)));
    chk({"overflow", s}, 64'(o), 64'(m_ovf));
    chk({"drop_cnt", s}, 64'(c), 64'(m_drops));
  endtask

  task automatic check_all();
    check_dut("0", 1'b0, valid0, data0, idx0, last0, ovf0, cnt0);
    check_dut("1", 1'b1, valid1, data1, idx1, last1, ovf1, cnt1);
  endtask

  // pat 0: random bins, 1: re=k*16+1 im=-k, 2: re=im=k
  task automatic gen_frame(input int pat);
    for (int k = 0; k < BINS; k++) begin
      case (pat)
        1:       begin i_bins_re[k*N +: N] = 16'(k*16 + 1); i_bins_im[k*N +: N] = 16'(-k); end
        2:       begin i_bins_re[k*N +: N] = 16'(k);        i_bins_im[k*N +: N] = 16'(k);  end
        default: begin i_bins_re[k*N +: N] = 16'($urandom); i_bins_im[k*N +: N] = 16'($urandom); end
      endcase
    end
  endtask

  task automatic model_update(input logic rst, input logic done, input logic ready);
    bit xfer, rel, accept;
    frame_t f;
    if (rst) begin
      m_q.delete();
      m_beat  = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      xfer   = (m_q.size() > 0) && ready;
      rel    = xfer && (m_beat == BINS - 1);
      accept = done && ((int'(m_q.size()) - int'(rel)) < 2);
      m_ovf  = done && !accept;
      if (m_ovf && m_drops < 255) m_drops++;
      if (xfer) begin
        if (rel) begin
          void'(m_q.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (accept) begin
        f.re = i_bins_re;
        f.im = i_bins_im;
        m_q.push_back(f);
      end
    end
  endtask

  task automatic step(input logic rst, input logic done, input logic ready, input int pat);
    i_rst        = rst;
    i_frame_done = done;
    i_ready      = ready;
    if (done) gen_frame(pat);
    model_update(rst, done, ready);
    @(posedge i_clk);
    @(negedge i_clk);
    check_all();
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ready, 0);
  endtask

  initial begin
    bit hit;
    i_rst        = 1'b1;
    i_frame_done = 1'b0;
    i_ready      = 1'b0;
    i_bins_re    = '0;
    i_bins_im    = '0;
    @(negedge i_clk);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 0);

    // single frame, continuous ready
    step(1'b0, 1'b1, 1'b1, 1);
    idle(18, 1'b1);

    // back-to-back frames three cycles apart
    step(1'b0, 1'b1, 1'b1, 0);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 0);
    idle(34, 1'b1);

    // stall at beat 7
    step(1'b0, 1'b1, 1'b1, 0);
    idle(7, 1'b1);
    idle(5, 1'b0);
    idle(12, 1'b1);

    // overflow: three frames with the consumer stalled
    step(1'b0, 1'b1, 1'b0, 0);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0);
    idle(3, 1'b0);
    idle(36, 1'b1);

    // release collision: new frame on the last beat of the head bank while both banks are full
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_q.size() == 2 && m_beat == BINS - 1) begin
        step(1'b0, 1'b1, 1'b1, 0);
        hit = 1'b1;
      end else begin
        step(1'b0, 1'b0, 1'b1, 0);
      end
    end
    chk("collision_reached", 64'(hit), 64'(1));
    idle(36, 1'b1);

    // reset mid-frame at beat 4 (bit-reversed instance sees index pattern from bins k=k)
    step(1'b0, 1'b1, 1'b1, 2);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_beat == 4) hit = 1'b1;
      else step(1'b0, 1'b0, 1'b1, 0);
    end
    chk("reset_beat_reached", 64'(hit), 64'(1));
    step(1'b1, 1'b0, 1'b1, 0);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2);
    idle(18, 1'b1);

    // drop counter saturation
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 262; i++) step(1'b0, 1'b1, 1'b0, 0);
    idle(36, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
